cfg_stream_loader: RTL and testbench

Receives the fabric configuration bitstream serially and writes it into the fabric's configuration slots. Slot order is the 14-word, 33-bit image used by the fpga top: select, lta broadcast, sb a/b/c broadcast, sb d broadcast, lt_0..lt_7, sb e group 0, sb e group 1. The block hunts for a sync byte, then deserialises 14 words and issues one write per word. A trailing XOR checksum word sets either done or error. The fabric must treat its configuration as valid only while cfg_done is high.

---
 rtl/cfg_stream_loader.sv | 161 ++++++++++++++++
 tb/tb_cfg_stream_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cfg_stream_loader.sv
// Serial configuration loader: hunts for a sync byte, deserialises NUM_WORDS words into
// fabric config slots, then validates the frame against a trailing XOR checksum word.
module cfg_stream_loader #(
    parameter int unsigned       NUM_WORDS = 14,
    parameter int unsigned       WORD_W    = 33,
    parameter int unsigned       SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC      = 8'hA5
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic                         cfg_en,
    input  logic                         cfg_din,
    output logic                         cfg_busy,
    output logic                         wr_en,
    output logic [$clog2(NUM_WORDS)-1:0] wr_addr,
    output logic [WORD_W-1:0]            wr_data,
    output logic                         cfg_done,
    output logic                         cfg_error
);

    localparam int unsigned ADDR_W = $clog2(NUM_WORDS);
    localparam int unsigned CNT_W  = $clog2(WORD_W);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_WORDS - 1);

    localparam logic [2:0] StHunt  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StCheck = 3'd2;
    localparam logic [2:0] StDone  = 3'd3;
    localparam logic [2:0] StError = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [SYNC_W-1:0] sync_q, sync_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;

    logic [SYNC_W-1:0] sync_shift;
    logic [WORD_W-1:0] word_shift;
    logic              sync_hit;
    logic              word_last;

    assign sync_shift = {sync_q[SYNC_W-2:0], cfg_din};
    assign word_shift = {word_q[WORD_W-2:0], cfg_din};
    assign sync_hit   = (sync_shift == SYNC);
    assign word_last  = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        sync_d    = sync_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        error_d   = error_q;

        if (cfg_en) begin
            case (state_q)
                // DONE/ERROR keep their sticky flag but keep hunting for the next frame.
                StHunt, StDone, StError: begin
                    sync_d = sync_shift;
                    if (sync_hit) begin
                        state_d = StLoad;
                        sync_d  = '0;
                        cnt_d   = '0;
                        idx_d   = '0;
                        acc_d   = '0;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                    end
                end
                StLoad: begin
                    word_d = word_shift;
                    cnt_d  = cnt_q + 1'b1;
                    if (word_last) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q;
                        wr_data_d = word_shift;
                        acc_d     = acc_q ^ word_shift;
                        cnt_d     = '0;
                        idx_d     = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_d = StCheck;
                        end
                    end
                end
                StCheck: begin
                    word_d = word_shift;
                    cnt_d  = cnt_q + 1'b1;
                    if (word_last) begin
                        cnt_d  = '0;
                        sync_d = '0;
                        if (word_shift == acc_q) begin
                            done_d  = 1'b1;
                            state_d = StDone;
                        end else begin
                            error_d = 1'b1;
                            state_d = StError;
                        end
                    end
                end
                default: begin
                    state_d = StHunt;
                    sync_d  = '0;
                end
            endcase
        end

        busy_d = (state_d == StLoad) || (state_d == StCheck);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= StHunt;
            sync_q    <= '0;
            word_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
        end
    end

    assign cfg_busy  = busy_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cfg_done  = done_q;
    assign cfg_error = error_q;

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed bench for cfg_stream_loader: clean, bad-checksum, gapped, near-miss preamble,
// mid-frame reset and back-to-back frames, checked with immediate assertions.
module tb_cfg_stream_loader;

    logic        clock;
    logic        clear;
    logic        cfg_en;
    logic        cfg_din;
    logic        cfg_busy;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [32:0] wr_data;
    logic        cfg_done;
    logic        cfg_error;

    int n_cmp = 0;
    int n_err = 0;
    bit gap_mode = 1'b0;

    logic [3:0]  wa[$];
    logic [32:0] wd[$];

    cfg_stream_loader dut (
        .clock     (clock),
        .clear     (clear),
        .cfg_en    (cfg_en),
        .cfg_din   (cfg_din),
        .cfg_busy  (cfg_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write-strobe recorder, sampled mid-cycle.
    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        while (gap_mode && ($urandom_range(1, 0) == 1)) begin
            cfg_en = 1'b0;
            cfg_din = ~b;
            @(negedge clock);
        end
        cfg_en  = 1'b1;
        cfg_din = b;
        @(negedge clock);
        cfg_en  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [32:0] v);
        for (int i = 32; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic check_writes(input string tag, input logic [32:0] base, input bit add_k);
        logic [32:0] exp_d;
        check($sformatf("%s wr_count", tag), 64'(wa.size()), 64'd14);
        for (int k = 0; k < 14 && k < wa.size(); k++) begin
            exp_d = add_k ? (base | 33'(k)) : base;
            check($sformatf("%s addr%0d", tag, k), 64'(wa[k]), 64'(k));
            check($sformatf("%s data%0d", tag, k), 64'(wd[k]), 64'(exp_d));
        end
    endtask

    initial begin
        logic [32:0] w;
        logic [32:0] acc;

        clear   = 1'b0;
        cfg_en  = 1'b0;
        cfg_din = 1'b0;
        repeat (3) @(negedge clock);
        check("rst busy", 64'(cfg_busy), 64'd0);
        check("rst wr_en", 64'(wr_en), 64'd0);
        check("rst wr_addr", 64'(wr_addr), 64'd0);
        check("rst wr_data", 64'(wr_data), 64'd0);
        check("rst done", 64'(cfg_done), 64'd0);
        check("rst error", 64'(cfg_error), 64'd0);
        clear = 1'b1;
        @(negedge clock);

        // 1: clean frame, words k, checksum 1
        wa.delete(); wd.delete();
        send_byte(8'hA5);
        check("t1 busy after sync", 64'(cfg_busy), 64'd1);
        for (int k = 0; k < 14; k++) send_word(33'(k));
        check("t1 busy in check", 64'(cfg_busy), 64'd1);
        check("t1 done before csum", 64'(cfg_done), 64'd0);
        send_word(33'h1);
        check("t1 done", 64'(cfg_done), 64'd1);
        check("t1 error", 64'(cfg_error), 64'd0);
        check("t1 busy after", 64'(cfg_busy), 64'd0);
        check_writes("t1", 33'h0, 1'b1);
        repeat (3) @(negedge clock);
        check("t1 hold wr_en", 64'(wr_en), 64'd0);
        check("t1 hold addr", 64'(wr_addr), 64'd13);
        check("t1 hold data", 64'(wr_data), 64'd13);
        check("t1 done sticky", 64'(cfg_done), 64'd1);

        // 6: back-to-back all-ones frame, checksum 0
        wa.delete(); wd.delete();
        send_byte(8'hA5);
        check("t6 done cleared", 64'(cfg_done), 64'd0);
        for (int k = 0; k < 14; k++) send_word(33'h1_FFFF_FFFF);
        send_word(33'h0);
        check("t6 done", 64'(cfg_done), 64'd1);
        check("t6 error", 64'(cfg_error), 64'd0);
        check_writes("t6", 33'h1_FFFF_FFFF, 1'b0);

        // 2: bad checksum
        wa.delete(); wd.delete();
        send_byte(8'hA5);
        for (int k = 0; k < 14; k++) send_word(33'(k));
        send_word(33'h0);
        check("t2 error", 64'(cfg_error), 64'd1);
        check("t2 done", 64'(cfg_done), 64'd0);
        check("t2 busy", 64'(cfg_busy), 64'd0);
        check_writes("t2", 33'h0, 1'b1);

        // 3: same clean frame with random cfg_en gaps
        wa.delete(); wd.delete();
        gap_mode = 1'b1;
        send_byte(8'hA5);
        check("t3 error cleared", 64'(cfg_error), 64'd0);
        for (int k = 0; k < 14; k++) send_word(33'(k));
        send_word(33'h1);
        gap_mode = 1'b0;
        check("t3 done", 64'(cfg_done), 64'd1);
        check("t3 error", 64'(cfg_error), 64'd0);
        repeat (2) @(negedge clock);
        check_writes("t3", 33'h0, 1'b1);

        // 4: near-miss preamble A4 (shares A5 prefix) must not sync early
        wa.delete(); wd.delete();
        send_byte(8'hA4);
        check("t4 busy after A4", 64'(cfg_busy), 64'd0);
        check("t4 done sticky", 64'(cfg_done), 64'd1);
        send_byte(8'hA5);
        check("t4 busy after A5", 64'(cfg_busy), 64'd1);
        check("t4 done cleared", 64'(cfg_done), 64'd0);
        acc = '0;
        for (int k = 0; k < 14; k++) begin
            w = 33'h1_5A5A_5A50 | 33'(k);
            acc = acc ^ w;
            send_word(w);
        end
        send_word(acc);
        check("t4 done", 64'(cfg_done), 64'd1);
        check_writes("t4", 33'h1_5A5A_5A50, 1'b1);

        // 5: reset after word 6's write, then fresh frame
        send_byte(8'hA5);
        for (int k = 0; k < 7; k++) send_word(33'(k));
        check("t5 wr_en word6", 64'(wr_en), 64'd1);
        check("t5 addr word6", 64'(wr_addr), 64'd6);
        clear = 1'b0;
        repeat (2) @(negedge clock);
        check("t5 rst busy", 64'(cfg_busy), 64'd0);
        check("t5 rst wr_en", 64'(wr_en), 64'd0);
        check("t5 rst addr", 64'(wr_addr), 64'd0);
        check("t5 rst data", 64'(wr_data), 64'd0);
        check("t5 rst done", 64'(cfg_done), 64'd0);
        clear = 1'b1;
        @(negedge clock);
        wa.delete(); wd.delete();
        send_byte(8'hA5);
        for (int k = 0; k < 14; k++) send_word(33'(k));
        check("t5 done before csum", 64'(cfg_done), 64'd0);
        send_word(33'h1);
        check("t5 done", 64'(cfg_done), 64'd1);
        check_writes("t5", 33'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
